linebuffer_scheduler: RTL and testbench
=======================================

// Module: linebuffer_scheduler
// PURPOSE
//  Sequences the double-buffered scanline RAM pair. Per line: clears the draw buffer
//  to BG_COLOR, hands it to the sprite/tile draw engine, then issues the one-cycle
//  buffer swap at the line boundary. Sits between VGA timing, the draw engine and the
//  linebuffer draw-side ports; owns that write port and arbitrates clear engine vs drawer.
// PARAMETERS
//  H_ACTIVE  640      pixels per line; clear length; pixel address range 0..H_ACTIVE-1
//  V_ACTIVE  480      active lines; next_line >= V_ACTIVE is vblank
//  BG_COLOR  16'h0000 value written to every pixel during clear
// PORTS
//  clk                  in   1    system clock
//  reset_n              in   1    asynchronous, active-low reset
//  line_tick            in   1    1-cycle pulse from VGA timing at the swap point of each line
//  next_line            in   10   line displayed after this tick; valid with line_tick
//  switch               out  1    1-cycle swap pulse to linebuffer
//  draw_start           out  1    1-cycle pulse: drawer may begin line draw_line
//  draw_abort           out  1    1-cycle pulse: drawer must drop current line
//  draw_line            out  10   line currently being prepared
//  draw_done            in   1    1-cycle pulse from drawer: line complete
//  drw_addr_tile        in   6    drawer tile address; drw_data_tile in 256; drw_wren_tile in 1
//  drw_addr_pixel       in   10   drawer pixel address; drw_data_pixel in 16; drw_wren_pixel in 1
//  lb_addr_tile         out  6    linebuffer draw-side tile address; lb_data_tile out 256; lb_wren_tile out 1
//  lb_addr_pixel        out  10   linebuffer draw-side pixel address; lb_data_pixel out 16; lb_wren_pixel out 1
//  line_ready           out  1    high in READY
//  underrun_count       out  16   saturating count of missed lines (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state CLEAR_INIT. switch, draw_start, draw_abort, lb_wren_*, line_ready = 0.
//    draw_line = 0; clear address = 0; underrun_count = 0. Reset mid-line discards work.
//  States: CLEAR -> DRAW -> READY; CLEAR_INIT behaves as CLEAR, entered only from reset.
//  CLEAR: one write per cycle; lb_addr_pixel = 0..H_ACTIVE-1, lb_data_pixel = BG_COLOR,
//    lb_wren_pixel = 1, lb_wren_tile = 0; exactly H_ACTIVE cycles. Next cycle: DRAW,
//    draw_start pulses once.
//  DRAW: lb_* = drw_* combinationally. Wait for draw_done, then READY.
//  Outside DRAW, drw_* are ignored; lb_wren_tile and lb_wren_pixel are 0 except for
//    clear writes.
//  READY: line_ready = 1; hold until a line_tick with next_line < V_ACTIVE.
//  line_tick with next_line < V_ACTIVE:
//    - READY: switch = 1 the cycle after the tick. Set
//      draw_line = (next_line+1 == V_ACTIVE) ? 0 : next_line+1. Enter CLEAR.
//      Clear writes start the cycle after switch.
//    - CLEAR/DRAW (underrun): no switch; the display repeats the stale buffer.
//      In DRAW, draw_abort pulses. Set draw_line = next line as above. Restart CLEAR at
//      address 0. Increment underrun_count.
//  line_tick with next_line >= V_ACTIVE (vblank): no switch, no state change.
//    Line 0 is prepared and held in READY.
//  draw_done on the same cycle as line_tick in DRAW: done wins; treat the line as READY
//    and swap.
//  draw_done outside DRAW: ignored.
//  All control outputs are registered. lb_* is a registered mux select plus
//    combinational data path.
// CONFIGURATION
//  LB_UNDERRUN_CNT_EN defined: underrun_count increments on each underrun and
//    saturates at 16'hFFFF.
//  LB_UNDERRUN_CNT_EN undefined: counter logic is not built; underrun_count is tied to
//    0. Underrun handling is otherwise identical.
// STRUCTURE
//  Shared package linebuffer_pkg:
//    - sched_state_t enum {CLEAR_INIT, CLEAR, DRAW, READY}
//    - LB_TILE_AW = 6, LB_TILE_DW = 256, LB_PIX_AW = 10, LB_PIX_DW = 16
//  Sub-module linebuffer_clear_ctr: start pulse, address counter, done pulse at
//    H_ACTIVE-1.
//  The top level holds the FSM, the port mux and the underrun logic.
// TESTING
//  1. Release reset, drawer answers draw_done 20 cycles after draw_start
//     -> 640 writes of 0 at addr 0..639, then draw_start with draw_line=0, then
//     line_ready=1.
//  2. READY, line_tick next_line=5 -> switch high exactly 1 cycle after the tick,
//     draw_line=6, and the first clear write at addr 0 on the following cycle.
//  3. line_tick next_line=479 from READY -> draw_line=0. Ticks with next_line=480..524
//     -> no switch; state stays READY.
//  4. line_tick during CLEAR at addr 300 -> no switch, clear restarts at addr 0, and
//     underrun_count=1 (0 with macro undefined).
//     line_tick in DRAW -> draw_abort pulse, no switch.
//  5. draw_done and line_tick on the same cycle in DRAW -> switch pulses, no
//     draw_abort, no underrun.
//  6. drw_wren_pixel=1 during CLEAR/READY -> lb_wren_pixel follows the clear engine
//     only; no drawer write reaches the RAM.
//     Assert reset_n low mid-DRAW -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/linebuffer_pkg.sv
// Shared types and constants for the scanline linebuffer scheduler.
//   sched_state_t  : scheduler FSM encoding (CLEAR_INIT, CLEAR, DRAW, READY)
//   LB_*           : linebuffer draw-side port geometry (tile and pixel ports)
//   wrap_next_line : line to prepare after the given displayed line (wraps to 0)
package linebuffer_pkg;

  typedef enum logic [1:0] {
    CLEAR_INIT = 2'd0,
    CLEAR      = 2'd1,
    DRAW       = 2'd2,
    READY      = 2'd3
  } sched_state_t;

  localparam int LB_TILE_AW = 6;
  localparam int LB_TILE_DW = 256;
  localparam int LB_PIX_AW  = 10;
  localparam int LB_PIX_DW  = 16;

  // The line prepared next is the one after the line about to be shown; the
  // last active line wraps to line 0 so the first line of the next frame is
  // ready before vblank ends.
  function automatic logic [LB_PIX_AW-1:0] wrap_next_line(
    input logic [LB_PIX_AW-1:0] line,
    input logic [LB_PIX_AW-1:0] v_active
  );
    logic [LB_PIX_AW-1:0] nxt;
    nxt = line + 10'd1;
    return (nxt == v_active) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/linebuffer_clear_ctr.sv
// Clear engine address counter for the draw-side linebuffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : 1-cycle pulse, begins a clear sweep at address 0 next cycle
//   kill         : stops any sweep in progress and rewinds to address 0
//                  (takes priority over start)
//   addr         : current clear address, valid while active is high
//   active       : a clear write happens this cycle
//   done         : high during the write of address H_ACTIVE-1
module linebuffer_clear_ctr
  import linebuffer_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 kill,
  output logic [LB_PIX_AW-1:0] addr,
  output logic                 active,
  output logic                 done
);

  localparam logic [LB_PIX_AW-1:0] LAST_ADDR = LB_PIX_AW'(H_ACTIVE - 1);

  logic [LB_PIX_AW-1:0] addr_q, addr_d;
  logic                 active_q, active_d;

  assign done = active_q && (addr_q == LAST_ADDR);

  always_comb begin
    addr_d   = addr_q;
    active_d = active_q;
    if (kill) begin
      active_d = 1'b0;
      addr_d   = '0;
    end else if (start) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
        addr_d   = '0;
      end else begin
        addr_d = addr_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      active_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      active_q <= active_d;
    end
  end

  assign addr   = addr_q;
  assign active = active_q;

endmodule

// File: rtl/linebuffer_scheduler.sv
// Sequences the double-buffered scanline RAM pair: clears the draw buffer to
// BG_COLOR, hands it to the draw engine, and issues the buffer swap at the
// line boundary. Owns the linebuffer draw-side write port.
//   clk, reset_n            : clock, asynchronous active-low reset
//   line_tick, next_line    : swap-point pulse from VGA timing + line shown next
//   switch                  : 1-cycle buffer swap pulse to the linebuffer
//   draw_start/abort/line   : drawer control; draw_done is the drawer reply
//   drw_*                   : drawer write port (honoured only in DRAW)
//   lb_*                    : linebuffer draw-side write port
//   line_ready              : draw buffer holds a finished line
//   underrun_count          : saturating missed-line count
//   dbg_state               : scheduler FSM state (sched_state_t encoding)
// Build option: define LB_UNDERRUN_CNT_EN to build the underrun counter;
// otherwise underrun_count is tied to 0.
//
// Drawer protocol: draw_start is a 1-cycle pulse granting the buffer for line
// draw_line; the drawer may write from that cycle on and answers with a
// 1-cycle draw_done. A draw_abort pulse revokes the grant; the drawer must
// drop the line and wait for the next draw_start. draw_done outside DRAW is
// ignored.
module linebuffer_scheduler
  import linebuffer_pkg::*;
#(
  parameter int unsigned          H_ACTIVE = 640,
  parameter int unsigned          V_ACTIVE = 480,
  parameter logic [LB_PIX_DW-1:0] BG_COLOR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line_tick,
  input  logic [LB_PIX_AW-1:0]  next_line,
  output logic                  switch,
  output logic                  draw_start,
  output logic                  draw_abort,
  output logic [LB_PIX_AW-1:0]  draw_line,
  input  logic                  draw_done,
  input  logic [LB_TILE_AW-1:0] drw_addr_tile,
  input  logic [LB_TILE_DW-1:0] drw_data_tile,
  input  logic                  drw_wren_tile,
  input  logic [LB_PIX_AW-1:0]  drw_addr_pixel,
  input  logic [LB_PIX_DW-1:0]  drw_data_pixel,
  input  logic                  drw_wren_pixel,
  output logic [LB_TILE_AW-1:0] lb_addr_tile,
  output logic [LB_TILE_DW-1:0] lb_data_tile,
  output logic                  lb_wren_tile,
  output logic [LB_PIX_AW-1:0]  lb_addr_pixel,
  output logic [LB_PIX_DW-1:0]  lb_data_pixel,
  output logic                  lb_wren_pixel,
  output logic                  line_ready,
  output logic [15:0]           underrun_count,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_CLEAR_INIT = 2'(CLEAR_INIT);
  localparam logic [1:0] ST_CLEAR      = 2'(CLEAR);
  localparam logic [1:0] ST_DRAW       = 2'(DRAW);
  localparam logic [1:0] ST_READY      = 2'(READY);

  localparam logic [LB_PIX_AW-1:0] V_ACTIVE_W = LB_PIX_AW'(V_ACTIVE);

  logic [1:0]           state_q, state_d;
  logic                 switch_q, switch_d;
  logic                 draw_start_q, draw_start_d;
  logic                 draw_abort_q, draw_abort_d;
  logic [LB_PIX_AW-1:0] draw_line_q, draw_line_d;
  logic                 line_ready_q, line_ready_d;
  logic                 clr_start_q, clr_start_d;

  logic                 tick_live;
  logic                 swap_go;
  logic                 restart;
  logic                 clr_kill;
  logic [LB_PIX_AW-1:0] clr_addr;
  logic                 clr_active;
  logic                 clr_done;

  linebuffer_clear_ctr #(
    .H_ACTIVE (H_ACTIVE)
  ) u_clear_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start_q),
    .kill    (clr_kill),
    .addr    (clr_addr),
    .active  (clr_active),
    .done    (clr_done)
  );

  // Ticks into vblank never swap or disturb the FSM.
  assign tick_live = line_tick && (next_line < V_ACTIVE_W);

  always_comb begin
    state_d      = state_q;
    draw_start_d = 1'b0;
    draw_abort_d = 1'b0;
    draw_line_d  = draw_line_q;
    swap_go      = 1'b0;
    restart      = 1'b0;
    case (state_q)
      ST_CLEAR_INIT, ST_CLEAR: begin
        if (tick_live) begin
          restart = 1'b1;
        end else if (clr_done) begin
          state_d      = ST_DRAW;
          draw_start_d = 1'b1;
        end
      end
      ST_DRAW: begin
        // A done arriving with the tick still counts: the line is complete.
        if (draw_done) begin
          if (tick_live) swap_go = 1'b1;
          else           state_d = ST_READY;
        end else if (tick_live) begin
          restart      = 1'b1;
          draw_abort_d = 1'b1;
        end
      end
      ST_READY: begin
        if (tick_live) swap_go = 1'b1;
      end
      default: state_d = ST_CLEAR_INIT;
    endcase
    // Both a swap and an underrun start preparing the following line. The
    // clear start is delayed a cycle so the first write lands after switch.
    clr_kill    = swap_go || restart;
    clr_start_d = swap_go || restart;
    if (swap_go || restart) begin
      state_d     = ST_CLEAR;
      draw_line_d = wrap_next_line(next_line, V_ACTIVE_W);
    end
    switch_d     = swap_go;
    line_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR_INIT;
      switch_q     <= 1'b0;
      draw_start_q <= 1'b0;
      draw_abort_q <= 1'b0;
      draw_line_q  <= '0;
      line_ready_q <= 1'b0;
      // Kicks off the first clear sweep right after reset releases.
      clr_start_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      switch_q     <= switch_d;
      draw_start_q <= draw_start_d;
      draw_abort_q <= draw_abort_d;
      draw_line_q  <= draw_line_d;
      line_ready_q <= line_ready_d;
      clr_start_q  <= clr_start_d;
    end
  end

`ifdef LB_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (restart && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) underrun_cnt_q <= '0;
    else          underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_count = underrun_cnt_q;
`else
  logic unused_restart;
  assign unused_restart = restart;
  assign underrun_count = '0;
`endif

  // Port mux: the select is the registered state, the data path is
  // combinational so drawer writes reach the RAM in the same cycle.
  always_comb begin
    if (state_q == ST_DRAW) begin
      lb_addr_tile  = drw_addr_tile;
      lb_data_tile  = drw_data_tile;
      lb_wren_tile  = drw_wren_tile;
      lb_addr_pixel = drw_addr_pixel;
      lb_data_pixel = drw_data_pixel;
      lb_wren_pixel = drw_wren_pixel;
    end else begin
      lb_addr_tile  = '0;
      lb_data_tile  = '0;
      lb_wren_tile  = 1'b0;
      lb_addr_pixel = clr_addr;
      lb_data_pixel = BG_COLOR;
      lb_wren_pixel = clr_active;
    end
  end

  assign switch     = switch_q;
  assign draw_start = draw_start_q;
  assign draw_abort = draw_abort_q;
  assign draw_line  = draw_line_q;
  assign line_ready = line_ready_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_linebuffer_scheduler.sv
`timescale 1ns/1ps
module tb_linebuffer_scheduler;
  import linebuffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         line_tick;
  logic [9:0]   next_line;
  logic         switch_o;
  logic         draw_start;
  logic         draw_abort;
  logic [9:0]   draw_line;
  logic         draw_done;
  logic [5:0]   drw_addr_tile;
  logic [255:0] drw_data_tile;
  logic         drw_wren_tile;
  logic [9:0]   drw_addr_pixel;
  logic [15:0]  drw_data_pixel;
  logic         drw_wren_pixel;
  logic [5:0]   lb_addr_tile;
  logic [255:0] lb_data_tile;
  logic         lb_wren_tile;
  logic [9:0]   lb_addr_pixel;
  logic [15:0]  lb_data_pixel;
  logic         lb_wren_pixel;
  logic         line_ready;
  logic [15:0]  underrun_count;
  logic [1:0]   dbg_state;

  linebuffer_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_tick      (line_tick),
    .next_line      (next_line),
    .switch         (switch_o),
    .draw_start     (draw_start),
    .draw_abort     (draw_abort),
    .draw_line      (draw_line),
    .draw_done      (draw_done),
    .drw_addr_tile  (drw_addr_tile),
    .drw_data_tile  (drw_data_tile),
    .drw_wren_tile  (drw_wren_tile),
    .drw_addr_pixel (drw_addr_pixel),
    .drw_data_pixel (drw_data_pixel),
    .drw_wren_pixel (drw_wren_pixel),
    .lb_addr_tile   (lb_addr_tile),
    .lb_data_tile   (lb_data_tile),
    .lb_wren_tile   (lb_wren_tile),
    .lb_addr_pixel  (lb_addr_pixel),
    .lb_data_pixel  (lb_data_pixel),
    .lb_wren_pixel  (lb_wren_pixel),
    .line_ready     (line_ready),
    .underrun_count (underrun_count),
    .dbg_state      (dbg_state)
  );

`ifdef LB_UNDERRUN_CNT_EN
  localparam int UR_STEP = 1;
`else
  localparam int UR_STEP = 0;
`endif

  localparam logic [1:0] S_CLEAR = 2'(CLEAR);
  localparam logic [1:0] S_DRAW  = 2'(DRAW);
  localparam logic [1:0] S_READY = 2'(READY);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];   // expected clear-write addresses, in order
  logic       mon_en = 1'b0;
  logic [9:0] mon_exp;
  string      mon_tag;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write outside DRAW must be the next expected clear write of BG_COLOR.
  always @(negedge clk) begin
    if (mon_en && reset_n && dbg_state != S_DRAW && (lb_wren_pixel || lb_wren_tile)) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = "clr_wr";
      end else begin
        mon_exp = 10'h3FF;
        mon_tag = "clr_extra_wr";
      end
      check(mon_tag, {lb_wren_tile, lb_addr_pixel, lb_data_pixel}, {1'b0, mon_exp, 16'h0000});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int upto);
    for (int a = 0; a <= upto; a++) exp_q.push_back(10'(a));
  endtask

  task automatic tick(input logic [9:0] nl);
    line_tick = 1'b1;
    next_line = nl;
    next_cyc();
    line_tick = 1'b0;
  endtask

  task automatic wait_draw_start(input string tag);
    for (int i = 0; i < 800 && !draw_start; i++) next_cyc();
    check(tag, draw_start, 1);
    check({tag, "_clrlen"}, exp_q.size(), 0);
  endtask

  task automatic finish_line(input int delay);
    repeat (delay) next_cyc();
    draw_done = 1'b1;
    next_cyc();
    draw_done = 1'b0;
    check("line_ready", line_ready, 1);
  endtask

  // From READY: swap, then the clear begins one cycle after switch.
  task automatic swap_from_ready(input logic [9:0] nl, input logic [9:0] exp_line);
    push_clear(639);
    check("sw_before", switch_o, 0);
    tick(nl);
    check("sw_pulse", switch_o, 1);
    check("sw_draw_line", draw_line, exp_line);
    check("sw_no_wr", lb_wren_pixel, 0);
    next_cyc();
    check("sw_low", switch_o, 0);
    check("clr_first", {lb_wren_pixel, lb_addr_pixel}, {1'b1, 10'd0});
    wait_draw_start("ds");
    check("ds_line", draw_line, exp_line);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    line_tick      = 1'b0;
    next_line      = '0;
    draw_done      = 1'b0;
    drw_addr_tile  = '0;
    drw_data_tile  = '0;
    drw_wren_tile  = 1'b0;
    drw_addr_pixel = '0;
    drw_data_pixel = '0;
    drw_wren_pixel = 1'b0;
    repeat (3) next_cyc();

    // 1. reset state, initial clear, draw, ready
    check("rst_ctrl", {switch_o, draw_start, draw_abort, line_ready, lb_wren_pixel, lb_wren_tile}, 0);
    check("rst_draw_line", draw_line, 0);
    check("rst_underrun", underrun_count, 0);
    check("rst_addr", lb_addr_pixel, 0);
    push_clear(639);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    wait_draw_start("ds_init");
    check("ds_init_line", draw_line, 0);
    check("ds_init_state", dbg_state, S_DRAW);
    check("ds_init_notready", line_ready, 0);
    finish_line(20);
    check("ready_state", dbg_state, S_READY);

    // 2. swap on a live tick
    swap_from_ready(10'd5, 10'd6);
    finish_line(3);

    // 3. last line wraps to 0, then vblank ticks are ignored
    swap_from_ready(10'd479, 10'd0);
    finish_line(3);
    for (int nl = 480; nl <= 524; nl++) begin
      tick(10'(nl));
      check("vb_no_sw", switch_o, 0);
    end
    check("vb_state", dbg_state, S_READY);
    check("vb_ready", line_ready, 1);
    check("vb_line", draw_line, 0);

    // 4. underrun during CLEAR, then during DRAW
    push_clear(300);
    push_clear(639);
    tick(10'd0);
    check("ur_sw", switch_o, 1);
    check("ur_line1", draw_line, 1);
    for (int i = 0; i < 700 && !(lb_wren_pixel && lb_addr_pixel == 10'd300); i++) next_cyc();
    check("ur_reach300", {lb_wren_pixel, lb_addr_pixel}, {1'b1, 10'd300});
    tick(10'd1);
    check("ur_clr_nosw", switch_o, 0);
    check("ur_clr_noabort", draw_abort, 0);
    check("ur_clr_gap", lb_wren_pixel, 0);
    check("ur_clr_line", draw_line, 2);
    check("ur_clr_cnt", underrun_count, UR_STEP);
    check("ur_clr_state", dbg_state, S_CLEAR);
    next_cyc();
    check("ur_clr_restart", {lb_wren_pixel, lb_addr_pixel}, {1'b1, 10'd0});
    wait_draw_start("ds_ur");
    check("ds_ur_line", draw_line, 2);
    repeat (3) next_cyc();
    push_clear(639);
    tick(10'd2);
    check("ur_drw_abort", draw_abort, 1);
    check("ur_drw_nosw", switch_o, 0);
    check("ur_drw_line", draw_line, 3);
    check("ur_drw_cnt", underrun_count, 2 * UR_STEP);
    check("ur_drw_state", dbg_state, S_CLEAR);
    next_cyc();
    check("ur_abort_pulse", draw_abort, 0);
    wait_draw_start("ds_ab");
    finish_line(4);

    // 5. draw_done and line_tick together in DRAW
    swap_from_ready(10'd3, 10'd4);
    repeat (5) next_cyc();
    push_clear(639);
    draw_done = 1'b1;
    tick(10'd4);
    draw_done = 1'b0;
    check("tie_sw", switch_o, 1);
    check("tie_noabort", draw_abort, 0);
    check("tie_cnt", underrun_count, 2 * UR_STEP);
    check("tie_line", draw_line, 5);
    next_cyc();
    wait_draw_start("ds_tie");
    finish_line(2);

    // 6. drawer writes are blocked outside DRAW, pass through in DRAW
    drw_wren_pixel = 1'b1;
    drw_addr_pixel = 10'h155;
    drw_data_pixel = 16'hBEEF;
    drw_wren_tile  = 1'b1;
    drw_addr_tile  = 6'h2A;
    drw_data_tile  = {8{32'hA5C3_0F1E}};
    #1;
    check("blk_ready", {lb_wren_pixel, lb_wren_tile}, 0);
    swap_from_ready(10'd7, 10'd8);
    #1;
    check("pass_pix", {lb_wren_pixel, lb_addr_pixel, lb_data_pixel}, {1'b1, 10'h155, 16'hBEEF});
    check("pass_tile", {lb_wren_tile, lb_addr_tile}, {1'b1, 6'h2A});
    check("pass_tile_data", lb_data_tile, {8{32'hA5C3_0F1E}});
    mon_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", {switch_o, draw_start, draw_abort, line_ready, lb_wren_pixel, lb_wren_tile}, 0);
    check("arst_line", draw_line, 0);
    check("arst_pix", {lb_addr_pixel, lb_data_pixel}, 0);
    check("arst_tile", {lb_addr_tile, lb_data_tile}, 0);
    check("arst_cnt", underrun_count, 0);
    drw_wren_pixel = 1'b0;
    drw_wren_tile  = 1'b0;
    next_cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
